// File: rtl/rs232_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx_if
// Description : Serial line and received-byte signals of the RS-232 receiver.
//               The master side is the receiver. The slave side is the
//               line driver and byte consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs232_rx_if;
  logic       RX;
  logic [7:0] RX_DATA;
  logic       RX_DONE;
  logic       FRAME_ERR;
  logic       BUSY;

  modport master (
    input  RX,
    output RX_DATA,
    output RX_DONE,
    output FRAME_ERR,
    output BUSY
  );

  modport slave (
    output RX,
    input  RX_DATA,
    input  RX_DONE,
    input  FRAME_ERR,
    input  BUSY
  );
endinterface
`default_nettype wire

// File: rtl/rs232_rx.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx
// Description : 8N1 UART receiver. Oversamples RX with the system clock and
//               samples each bit at mid-bit. Emits a one-cycle RX_DONE with
//               the byte, or a one-cycle FRAME_ERR when the stop bit is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  rs232_rx_if.master bus
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  // Too few clocks per bit leaves no room to find mid-bit reliably.
  generate
    if (DIV < 8) begin : g_div_check
      $error("rs232_rx: CLK_FREQ/BAUD must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             sync1_q;
  logic             rx_s_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.RX;
      rx_s_q  <= sync1_q;
    end
  end

  // Receiver state, counters and registered outputs.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: strobes default low, everything else holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MID) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            // Line went high again before mid-start: a glitch.
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Returning to IDLE at mid-stop leaves margin for a back-to-back start.
            data_d  = sh_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.RX_DATA   = data_q;
  assign bus.RX_DONE   = done_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rs232_rx
// Description : Self-checking bench for rs232_rx. One instance at the default
//               rates for the directed scenarios, one fast instance (10 clocks
//               per bit) for the vector table and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx;

  localparam int  CLK_HZ   = 50000000;
  localparam int  BAUD_A   = 115200;
  localparam int  BAUD_B   = 5000000;
  localparam int  DIV_A    = CLK_HZ / BAUD_A;
  localparam int  HALF_A   = DIV_A / 2;
  localparam int  DIV_B    = CLK_HZ / BAUD_B;
  localparam int  HALF_B   = DIV_B / 2;
  localparam real BIT_A_NS = 1.0e9 / BAUD_A;
  localparam real BIT_B_NS = 1.0e9 / BAUD_B;

  typedef struct {
    bit          is_done;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         stop_hi;
    bit         exp_done;
    logic [7:0] exp_data;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [7:0]  last_good [2];
  int unsigned done_cyc_a[$];

  rs232_rx_if ifa ();
  rs232_rx_if ifb ();

  rs232_rx #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_A)) u_dut_a (
    .CLK_50MHZ (clk),
    .RST       (rst_n),
    .bus       (ifa)
  );

  rs232_rx #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_B)) u_dut_b (
    .CLK_50MHZ (clk),
    .RST       (rst_n),
    .bus       (ifb)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) ifa.RX = v;
    else        ifb.RX = v;
  endtask

  task automatic push_exp(input int d, input bit is_done, input logic [7:0] data, input int unsigned c);
    exp_t e;
    e.is_done = is_done;
    e.data    = data;
    e.cyc     = c;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  task automatic mon(input int d, input logic done, input logic ferr, input logic [7:0] data);
    exp_t e;
    bit   have;
    if (done === 1'b1 || ferr === 1'b1) begin
      have = (d == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
      if (!have) begin
        total++;
        bad++;
        $display("FAIL unexpected_event dut%0d: done=%0b ferr=%0b data=%02h, want no event",
                 d, done, ferr, data);
      end else begin
        if (d == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        chk($sformatf("dut%0d_done_ferr_exclusive", d), {31'd0, done & ferr}, 32'd0);
        chk($sformatf("dut%0d_event_kind_done", d), {31'd0, done}, {31'd0, e.is_done});
        chk($sformatf("dut%0d_rx_data", d), {24'd0, data}, {24'd0, e.data});
        chk_win($sformatf("dut%0d_event_cycle", d), int'(cyc), int'(e.cyc) - 2, int'(e.cyc) + 2);
        if (d == 0 && done === 1'b1) done_cyc_a.push_back(cyc);
      end
    end
  endtask

  // Sample DUT strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifa.RX_DONE, ifa.FRAME_ERR, ifa.RX_DATA);
      mon(1, ifb.RX_DONE, ifb.FRAME_ERR, ifb.RX_DATA);
    end
  end

  // Drives one frame starting on a falling clock edge; leaves the line at the stop level.
  task automatic send_frame(input int d, input logic [7:0] b, input bit stop_hi, input real bit_ns,
                            input bit push, input bit exp_done, input logic [7:0] exp_data);
    realtime t0;
    realtime dly;
    int      half;
    int      div;
    half = (d == 0) ? HALF_A : HALF_B;
    div  = (d == 0) ? DIV_A  : DIV_B;
    @(negedge clk);
    // Byte is reported at mid-stop: 2 sync + 1 register + half a bit + 9 bits.
    if (push) push_exp(d, exp_done, exp_data, cyc + 3 + half + 9 * div);
    t0 = $realtime;
    set_rx(d, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      dly = t0 + k * bit_ns - $realtime;
      #(dly);
      set_rx(d, (k < 9) ? b[k-1] : stop_hi);
    end
    dly = t0 + 10 * bit_ns - $realtime;
    #(dly);
  endtask

  // Reference model: good stop bit reports the byte, bad stop bit keeps the old one.
  task automatic model_frame(input int d, input logic [7:0] b, input bit stop_hi, input real bit_ns);
    logic [7:0] exp_data;
    exp_data = stop_hi ? b : last_good[d];
    if (stop_hi) last_good[d] = b;
    send_frame(d, b, stop_hi, bit_ns, 1'b1, stop_hi, exp_data);
  endtask

  task automatic idle(input int d, input real nbits, input real bit_ns);
    realtime dly;
    set_rx(d, 1'b1);
    dly = nbits * bit_ns;
    #(dly);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
  endtask

  vec_t tbl [8];

  initial begin
    realtime     t0;
    realtime     dly;
    int unsigned g;
    logic [7:0]  rb;
    bit          rs;
    int          gap;

    tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    tbl[2] = '{8'h55, 1'b0, 1'b0, 8'hFF};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 8'h01};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80};
    tbl[5] = '{8'h5A, 1'b0, 1'b0, 8'h80};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
    tbl[7] = '{8'h3C, 1'b1, 1'b1, 8'h3C};

    ifa.RX = 1'b1;
    ifb.RX = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    chk("a_reset_data",  {24'd0, ifa.RX_DATA}, 32'd0);
    chk("a_reset_done",  {31'd0, ifa.RX_DONE}, 32'd0);
    chk("a_reset_ferr",  {31'd0, ifa.FRAME_ERR}, 32'd0);
    chk("a_reset_busy",  {31'd0, ifa.BUSY}, 32'd0);
    chk("b_reset_data",  {24'd0, ifb.RX_DATA}, 32'd0);
    chk("b_reset_done",  {31'd0, ifb.RX_DONE}, 32'd0);
    chk("b_reset_ferr",  {31'd0, ifb.FRAME_ERR}, 32'd0);
    chk("b_reset_busy",  {31'd0, ifb.BUSY}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Vector table on the fast instance.
    for (int i = 0; i < 8; i++) begin
      send_frame(1, tbl[i].b, tbl[i].stop_hi, BIT_B_NS, 1'b1, tbl[i].exp_done, tbl[i].exp_data);
      last_good[1] = tbl[i].exp_data;
      idle(1, 2.0, BIT_B_NS);
    end
    wait_drain(200);

    // Random frames on the fast instance, including zero-gap back-to-back.
    for (int i = 0; i < 30; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 99) < 85);
      gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
      model_frame(1, rb, rs, BIT_B_NS);
      if (gap > 0) idle(1, real'(gap), BIT_B_NS);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    idle(1, 2.0, BIT_B_NS);
    wait_drain(200);

    // 0x55 at nominal rate, timing checked by the scoreboard window.
    model_frame(0, 8'h55, 1'b1, BIT_A_NS);
    idle(0, 2.0, BIT_A_NS);

    // 0xA5 then 0x3C back-to-back: strobes ten bit periods apart.
    done_cyc_a.delete();
    model_frame(0, 8'hA5, 1'b1, BIT_A_NS);
    model_frame(0, 8'h3C, 1'b1, BIT_A_NS);
    idle(0, 2.0, BIT_A_NS);
    chk("b2b_done_count", done_cyc_a.size(), 32'd2);
    if (done_cyc_a.size() == 2)
      chk_win("b2b_done_spacing", int'(done_cyc_a[1] - done_cyc_a[0]), 10 * DIV_A - 1, 10 * DIV_A + 1);

    // 100 ns glitch: BUSY rises, then falls by HALF+3 cycles with no strobe.
    @(negedge clk);
    g = cyc;
    set_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("glitch_busy_high", {31'd0, ifa.BUSY}, 32'd1);
    repeat (2) @(negedge clk);
    set_rx(0, 1'b1);
    while (cyc < g + HALF_A + 3) @(negedge clk);
    chk("glitch_busy_low", {31'd0, ifa.BUSY}, 32'd0);
    idle(0, 1.0, BIT_A_NS);

    // 0x81 with low stop bit, line held low 3 more bits, then 0x0F.
    model_frame(0, 8'h81, 1'b0, BIT_A_NS);
    dly = 3.0 * BIT_A_NS;
    #(dly);
    chk("break_busy_high", {31'd0, ifa.BUSY}, 32'd1);
    idle(0, 2.0, BIT_A_NS);
    chk("break_busy_low", {31'd0, ifa.BUSY}, 32'd0);
    model_frame(0, 8'h0F, 1'b1, BIT_A_NS);
    idle(0, 2.0, BIT_A_NS);

    // 0x6E at +3 % and -3 % transmitter rate.
    model_frame(0, 8'h6E, 1'b1, BIT_A_NS / 1.03);
    idle(0, 2.0, BIT_A_NS);
    model_frame(0, 8'h6E, 1'b1, BIT_A_NS / 0.97);
    idle(0, 2.0, BIT_A_NS);
    wait_drain(500);

    // Reset in data bit 4 of a 0xC3 frame, then a clean 0xC3.
    rb = 8'hC3;
    @(negedge clk);
    t0 = $realtime;
    set_rx(0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      dly = t0 + k * BIT_A_NS - $realtime;
      #(dly);
      set_rx(0, rb[k-1]);
    end
    dly = t0 + 5.5 * BIT_A_NS - $realtime;
    #(dly);
    chk("midframe_busy_high", {31'd0, ifa.BUSY}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_data", {24'd0, ifa.RX_DATA}, 32'd0);
    chk("midframe_reset_done", {31'd0, ifa.RX_DONE}, 32'd0);
    chk("midframe_reset_ferr", {31'd0, ifa.FRAME_ERR}, 32'd0);
    chk("midframe_reset_busy", {31'd0, ifa.BUSY}, 32'd0);
    set_rx(0, 1'b1);
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2.0, BIT_A_NS);
    model_frame(0, 8'hC3, 1'b1, BIT_A_NS);
    idle(0, 2.0, BIT_A_NS);

    wait_drain(5000);
    chk("a_expectations_left", q_a.size(), 32'd0);
    chk("b_expectations_left", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
